// File: rtl/adder_result_checker_if.sv
// Vector bus between the adder pair and the result checker.
// One sampled vector per cycle, qualified by valid.
interface adder_result_checker_if #(
  parameter int n = 64
);
  logic         valid;
  logic         cin;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [n-1:0] s_ref;
  logic         cout_ref;
  logic [n-1:0] s_duv;
  logic         cout_duv;

  modport master (
    output valid, cin, a, b,
    output s_ref, cout_ref,
    output s_duv, cout_duv
  );

  modport slave (
    input valid, cin, a, b,
    input s_ref, cout_ref,
    input s_duv, cout_duv
  );
endinterface

// File: rtl/adder_result_checker.sv
// Two-stage scoreboard comparing DUV and reference adder results.
// Counts vectors/mismatches, keeps the first failure, gives a verdict.
module adder_result_checker #(
  parameter int n     = 64,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [cnt_w-1:0] vec_total,
  adder_result_checker_if.slave vif,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [cnt_w-1:0] vec_count,
  output logic [cnt_w-1:0] err_count,
  output logic             err_flag,
  output logic [cnt_w-1:0] ff_idx,
  output logic [n-1:0]     ff_a,
  output logic [n-1:0]     ff_b,
  output logic             ff_cin,
  output logic [n-1:0]     ff_s_duv,
  output logic             ff_cout_duv
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [cnt_w-1:0] total;
  logic [cnt_w-1:0] acc;

  logic             p_v;
  logic [cnt_w-1:0] p_idx;
  logic [n-1:0]     p_a;
  logic [n-1:0]     p_b;
  logic             p_cin;
  logic [n-1:0]     p_s_ref;
  logic             p_cout_ref;
  logic [n-1:0]     p_s_duv;
  logic             p_cout_duv;

  logic             go;
  logic             take;
  logic             mm;
  logic [cnt_w-1:0] vc_nxt;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    go     = start && (state != RUN);
    take   = busy && vif.valid && (acc < total);
    mm     = {p_cout_duv, p_s_duv}
          != {p_cout_ref, p_s_ref};
    vc_nxt = vec_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      total       <= '0;
      acc         <= '0;
      pass        <= 1'b0;
      vec_count   <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      ff_idx      <= '0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_cin      <= 1'b0;
      ff_s_duv    <= '0;
      ff_cout_duv <= 1'b0;
      p_v         <= 1'b0;
      p_idx       <= '0;
      p_a         <= '0;
      p_b         <= '0;
      p_cin       <= 1'b0;
      p_s_ref     <= '0;
      p_cout_ref  <= 1'b0;
      p_s_duv     <= '0;
      p_cout_duv  <= 1'b0;
    end else if (go) begin
      total       <= vec_total;
      acc         <= '0;
      vec_count   <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      ff_idx      <= '0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_cin      <= 1'b0;
      ff_s_duv    <= '0;
      ff_cout_duv <= 1'b0;
      p_v         <= 1'b0;
      if (vec_total == '0) begin
        state <= DONE;
        pass  <= 1'b1;
      end else begin
        state <= RUN;
        pass  <= 1'b0;
      end
    end else if (busy) begin
      p_v <= take;
      if (take) begin
        p_idx      <= acc;
        p_a        <= vif.a;
        p_b        <= vif.b;
        p_cin      <= vif.cin;
        p_s_ref    <= vif.s_ref;
        p_cout_ref <= vif.cout_ref;
        p_s_duv    <= vif.s_duv;
        p_cout_duv <= vif.cout_duv;
        acc        <= acc + 1'b1;
      end
      if (p_v) begin
        vec_count <= vc_nxt;
        if (mm) begin
          if (err_count != '1)
            err_count <= err_count + 1'b1;
          err_flag <= 1'b1;
          // only the first failure of the run is kept
          if (!err_flag) begin
            ff_idx      <= p_idx;
            ff_a        <= p_a;
            ff_b        <= p_b;
            ff_cin      <= p_cin;
            ff_s_duv    <= p_s_duv;
            ff_cout_duv <= p_cout_duv;
          end
        end
        if (vc_nxt == total) begin
          state <= DONE;
          pass  <= !(err_flag || mm);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: random vectors vs a queue-based model.
// Second small instance exercises counter saturation.
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] vec_total;
  logic        busy, done, pass, err_flag;
  logic [15:0] vec_count, err_count, ff_idx;
  logic [63:0] ff_a, ff_b, ff_s_duv;
  logic        ff_cin, ff_cout_duv;

  logic        start2;
  logic [3:0]  tot2;
  logic        busy2, done2, pass2, err_flag2;
  logic [3:0]  vec_count2, err_count2, ff_idx2;
  logic [7:0]  ff_a2, ff_b2, ff_s_duv2;
  logic        ff_cin2, ff_cout_duv2;

  int checks = 0;
  int failures = 0;

  adder_result_checker_if #(.n(64)) vb ();
  adder_result_checker_if #(.n(8))  vs ();

  always #5 clk = ~clk;

  adder_result_checker #(.n(64), .cnt_w(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .vec_total(vec_total),
    .vif(vb.slave),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .err_flag(err_flag), .ff_idx(ff_idx),
    .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin),
    .ff_s_duv(ff_s_duv), .ff_cout_duv(ff_cout_duv)
  );

  adder_result_checker #(.n(8), .cnt_w(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .start(start2), .vec_total(tot2),
    .vif(vs.slave),
    .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec_count2), .err_count(err_count2),
    .err_flag(err_flag2), .ff_idx(ff_idx2),
    .ff_a(ff_a2), .ff_b(ff_b2), .ff_cin(ff_cin2),
    .ff_s_duv(ff_s_duv2), .ff_cout_duv(ff_cout_duv2)
  );

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 65'(busy), 65'(0));
    chk({tag, "_done"}, 65'(done), 65'(0));
    chk({tag, "_pass"}, 65'(pass), 65'(0));
    chk({tag, "_vc"}, 65'(vec_count), 65'(0));
    chk({tag, "_ec"}, 65'(err_count), 65'(0));
    chk({tag, "_ef"}, 65'(err_flag), 65'(0));
    chk({tag, "_ffa"}, 65'(ff_a), 65'(0));
    chk({tag, "_ffs"}, 65'(ff_s_duv), 65'(0));
  endtask

  // total, valid vectors to offer, gap percent (100 = strict toggle),
  // mismatch mask by vector index, index of the carry-overflow vector
  task automatic run(input string tag, input int total,
                     input int attempts, input int gap_pct,
                     input logic [31:0] emask, input int special);
    logic [63:0] qa[$], qb[$], qs[$];
    bit          qc[$], qco[$], qm[$];
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] rsum, dsum, msk;
    bit          v;
    int acc = 0, i = 0, c = 0, k = 0, ne = 0, fi = -1;
    @(negedge clk);
    start = 1'b1;
    vec_total = 16'(total);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, 65'(busy), 65'(total != 0));
    chk({tag, "_done_on"}, 65'(done), 65'(total == 0));
    while (i < attempts) begin
      if (gap_pct == 100) v = (c % 2 == 0);
      else v = (i == 0) || ($urandom_range(99) >= gap_pct);
      c++;
      if (v) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(1));
        if (i == special) begin
          ra = '1; rb = 64'd1; rc = 1'b0;
        end
        rsum = {1'b0, ra} + {1'b0, rb} + 65'(rc);
        dsum = rsum;
        if (i < 32 && emask[i]) begin
          if (i == special) dsum[64] = ~dsum[64];
          else begin
            msk = {1'($urandom_range(1)), $urandom, $urandom};
            if (msk == '0) msk = 65'd1;
            dsum ^= msk;
          end
        end
        vb.valid = 1'b1;
        vb.a = ra; vb.b = rb; vb.cin = rc;
        vb.s_ref = rsum[63:0]; vb.cout_ref = rsum[64];
        vb.s_duv = dsum[63:0]; vb.cout_duv = dsum[64];
        if (acc < total) begin
          qa.push_back(ra); qb.push_back(rb); qc.push_back(rc);
          qs.push_back(dsum[63:0]); qco.push_back(dsum[64]);
          qm.push_back(dsum != rsum);
          acc++;
        end
        i++;
      end else vb.valid = 1'b0;
      @(negedge clk);
    end
    vb.valid = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 65'(done), 65'(1));
    if (gap_pct == 0 && attempts == total && total > 0)
      chk({tag, "_latency"}, 65'(k), 65'(1));
    foreach (qm[j]) if (qm[j]) begin
      ne++;
      if (fi < 0) fi = j;
    end
    chk({tag, "_busy"}, 65'(busy), 65'(0));
    chk({tag, "_vc"}, 65'(vec_count), 65'(qm.size()));
    chk({tag, "_ec"}, 65'(err_count), 65'(ne));
    chk({tag, "_ef"}, 65'(err_flag), 65'(ne > 0));
    chk({tag, "_pass"}, 65'(pass), 65'(ne == 0));
    if (fi >= 0) begin
      chk({tag, "_ffidx"}, 65'(ff_idx), 65'(fi));
      chk({tag, "_ffa"}, 65'(ff_a), 65'(qa[fi]));
      chk({tag, "_ffb"}, 65'(ff_b), 65'(qb[fi]));
      chk({tag, "_ffcin"}, 65'(ff_cin), 65'(qc[fi]));
      chk({tag, "_ffs"}, 65'(ff_s_duv), 65'(qs[fi]));
      chk({tag, "_ffco"}, 65'(ff_cout_duv), 65'(qco[fi]));
    end else begin
      chk({tag, "_ffidx0"}, 65'(ff_idx), 65'(0));
      chk({tag, "_ffa0"}, 65'(ff_a), 65'(0));
    end
  endtask

  // all vectors mismatch; 20 offered against a total of 15
  task automatic small_run(input string tag);
    int acc = 0, k = 0, ne = 0;
    logic [8:0] rs;
    @(negedge clk);
    start2 = 1'b1;
    tot2 = 4'd15;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vs.valid = 1'b1;
      vs.a = 8'($urandom); vs.b = 8'($urandom);
      vs.cin = 1'($urandom_range(1));
      rs = {1'b0, vs.a} + {1'b0, vs.b} + 9'(vs.cin);
      vs.s_ref = rs[7:0]; vs.cout_ref = rs[8];
      vs.s_duv = rs[7:0] ^ 8'h01; vs.cout_duv = rs[8];
      if (acc < 15) begin acc++; ne++; end
      @(negedge clk);
    end
    vs.valid = 1'b0;
    while (!done2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 65'(done2), 65'(1));
    chk({tag, "_vc"}, 65'(vec_count2), 65'(acc));
    chk({tag, "_ec"}, 65'(err_count2), 65'(ne > 15 ? 15 : ne));
    chk({tag, "_pass"}, 65'(pass2), 65'(0));
    chk({tag, "_ffidx"}, 65'(ff_idx2), 65'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; vec_total = '0;
    start2 = 1'b0; tot2 = '0;
    vb.valid = 1'b0; vb.a = '0; vb.b = '0; vb.cin = 1'b0;
    vb.s_ref = '0; vb.cout_ref = 1'b0;
    vb.s_duv = '0; vb.cout_duv = 1'b0;
    vs.valid = 1'b0; vs.a = '0; vs.b = '0; vs.cin = 1'b0;
    vs.s_ref = '0; vs.cout_ref = 1'b0;
    vs.s_duv = '0; vs.cout_duv = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run("match4", 4, 4, 0, 32'h0, -1);
    run("ovf", 3, 3, 0, 32'h2, 1);
    run("two_err", 3, 3, 0, 32'h5, -1);
    run("zero", 0, 0, 0, 32'h0, -1);
    run("toggle", 2, 2, 100, 32'h0, -1);
    run("rnd", 8, 12, 30, $urandom, -1);
    run("rnd2", 6, 6, 0, $urandom, -1);

    @(negedge clk);
    start = 1'b1;
    vec_total = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vb.valid = 1'b1;
      vb.a = 64'd5; vb.b = 64'd3; vb.cin = 1'b0;
      vb.s_ref = 64'd8; vb.cout_ref = 1'b0;
      vb.s_duv = 64'd9; vb.cout_duv = 1'b0;
      @(negedge clk);
    end
    vb.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 5, 5, 0, 32'h0, -1);

    small_run("sat1");
    small_run("sat2");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
